// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared icache types and default geometry (16 frames, 32-bit words)
package cpu_types_pkg;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;
  typedef enum logic {IDLE, MISS} icache_state_t;
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: SETS-entry frame storage, combinational read, one sync write, sync valid clear
// Ports: CLK, nRST (sync active-low, clears valid bits only);
//        rd_idx -> rd_valid/rd_tag/rd_data (combinational);
//        wr_en/wr_idx/wr_tag/wr_data (written on rising edge, sets valid).
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS   = 1 << ICACHE_IDX_W,
  parameter int WORD_W = 32,
  parameter int IDX_W  = $clog2(SETS),
  parameter int TAG_W  = WORD_W - IDX_W - 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_data
);
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag  [SETS];
  logic [WORD_W-1:0] data [SETS];
  always_ff @(posedge CLK)
    if (!nRST) valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge CLK)
    if (wr_en) begin
      tag[wr_idx]  <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag[rd_idx];
  assign rd_data  = data[rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-word miss fill
// Ports: CLK, nRST (sync active-low);
//        fetch side: imemREN, imemaddr in; ihit, imemload out (hit is same-cycle);
//        memory side: iREN, iaddr out; iwait, iload in (iwait low = iload valid);
//        hit_count, miss_count out only when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS   = 1 << ICACHE_IDX_W,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  icache_state_t     state;
  logic [WORD_W-1:0] miss_addr;
  logic              f_valid;
  logic [TAG_W-1:0]  f_tag;
  logic              hit;
  logic              fill;
  logic              unused;
  icache_frame_array #(.SETS(SETS), .WORD_W(WORD_W)) frames (
    .CLK     (CLK),
    .nRST    (nRST),
    .rd_idx  (imemaddr[IDX_W+1:2]),
    .rd_valid(f_valid),
    .rd_tag  (f_tag),
    .rd_data (imemload),
    .wr_en   (fill),
    .wr_idx  (miss_addr[IDX_W+1:2]),
    .wr_tag  (miss_addr[WORD_W-1:IDX_W+2]),
    .wr_data (iload)
  );
  assign hit    = f_valid && f_tag == imemaddr[WORD_W-1:IDX_W+2];
  assign fill   = nRST && state == MISS && !iwait;
  assign ihit   = nRST && state == IDLE && imemREN && hit;
  assign iREN   = nRST && state == MISS;
  assign iaddr  = state == MISS ? miss_addr : '0;
  assign unused = &{1'b0, imemaddr[1:0]};
  // The fill always targets miss_addr, so fetch redirects during MISS never abandon the arbiter.
  always_ff @(posedge CLK)
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
`ifdef ICACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else if (state == IDLE) begin
      if (imemREN && !hit) begin
        state     <= MISS;
        miss_addr <= imemaddr;
      end
`ifdef ICACHE_STATS_EN
      if (imemREN && hit) hit_count <= hit_count + 1'b1;
      if (imemREN && !hit) miss_count <= miss_count + 1'b1;
`endif
    end else if (!iwait) state <= IDLE;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache
module tb_icache;
  logic        CLK = 1'b0;
  logic        nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int n_chk = 0;
  int n_ok  = 0;

  always #5 CLK = ~CLK;

  icache dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .imemREN (imemREN),
    .imemaddr(imemaddr),
    .ihit    (ihit),
    .imemload(imemload),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", t, got, exp);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // One fetch; on a miss memory holds iwait high for `waits` cycles, then returns d.
  task automatic access(input string t, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input bit miss);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    #3;
    check({t, " req ihit"}, {31'd0, ihit}, {31'd0, !miss});
    if (miss) begin
      step;
      for (int i = 0; i <= waits; i++) begin
        iwait = i != waits;
        iload = i == waits ? d : 32'hdead_beef;
        #3;
        check({t, " iREN"}, {31'd0, iREN}, 32'd1);
        check({t, " iaddr"}, iaddr, a);
        check({t, " miss ihit"}, {31'd0, ihit}, 32'd0);
        step;
      end
      iwait = 1'b1;
      #3;
      check({t, " fill ihit"}, {31'd0, ihit}, 32'd1);
    end
    check({t, " imemload"}, imemload, d);
    check({t, " idle iREN"}, {31'd0, iREN}, 32'd0);
    step;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = '0;
    step;
    step;
    #3;
    check("rst ihit", {31'd0, ihit}, 32'd0);
    check("rst iREN", {31'd0, iREN}, 32'd0);
    check("rst iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst hit_count", hit_count, 32'd0);
    check("rst miss_count", miss_count, 32'd0);
`endif
    imemREN = 1'b0;
    nRST = 1'b1;
    step;
    iwait = 1'b0;
    #3;
    check("idle iwait0 iREN", {31'd0, iREN}, 32'd0);
    step;
    #3;
    check("idle iwait0 stays", {31'd0, iREN}, 32'd0);
    step;

    access("cold", 32'h40, 32'h2408_0001, 3, 1'b1);
    access("hit", 32'h40, 32'h2408_0001, 0, 1'b0);
    access("hit ofs", 32'h42, 32'h2408_0001, 0, 1'b0);
    access("conflict", 32'h440, 32'h1111_0440, 1, 1'b1);
    access("evicted", 32'h40, 32'h2408_0001, 2, 1'b1);

    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    #3;
    check("redir req ihit", {31'd0, ihit}, 32'd0);
    step;
    imemaddr = 32'hC0;
    #3;
    check("redir iaddr0", iaddr, 32'h80);
    check("redir iREN0", {31'd0, iREN}, 32'd1);
    step;
    iwait = 1'b0; iload = 32'hD000_0080;
    #3;
    check("redir iaddr1", iaddr, 32'h80);
    step;
    iwait = 1'b1;
    #3;
    check("redir new miss ihit", {31'd0, ihit}, 32'd0);
    check("redir idle iREN", {31'd0, iREN}, 32'd0);
    step;
    #3;
    check("redir 2nd iREN", {31'd0, iREN}, 32'd1);
    check("redir 2nd iaddr", iaddr, 32'hC0);
    iwait = 1'b0; iload = 32'hD000_00C0;
    step;
    iwait = 1'b1;
    #3;
    check("redir 2nd ihit", {31'd0, ihit}, 32'd1);
    check("redir 2nd data", imemload, 32'hD000_00C0);
    imemREN = 1'b0;
    step;

    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
    #3;
    check("rstmiss req ihit", {31'd0, ihit}, 32'd0);
    step;
    #3;
    check("rstmiss iREN", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("rstmiss iREN comb", {31'd0, iREN}, 32'd0);
    step;
    imemREN = 1'b0;
    #3;
    check("rstmiss held iREN", {31'd0, iREN}, 32'd0);
    nRST = 1'b1;
    step;
    #3;
    check("rstmiss idle iREN", {31'd0, iREN}, 32'd0);
    check("rstmiss idle iaddr", iaddr, 32'd0);
    step;
    access("after rst", 32'h100, 32'hABCD_0100, 1, 1'b1);
    access("cleared C0", 32'hC4, 32'h5555_00C4, 0, 1'b1);
    access("other idx", 32'hC0, 32'h6666_00C0, 0, 1'b1);
    access("C4 kept", 32'hC4, 32'h5555_00C4, 0, 1'b0);

`ifdef ICACHE_STATS_EN
    imemREN = 1'b0; nRST = 1'b0;
    step;
    nRST = 1'b1;
    step;
    imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1;
    step;
    iwait = 1'b0; iload = 32'h0000_7000;
    step;
    iwait = 1'b1;
    #3;
    check("stats hit0", {31'd0, ihit}, 32'd1);
    step;
    imemaddr = 32'h4;
    step;
    iwait = 1'b0; iload = 32'h0000_7004;
    step;
    iwait = 1'b1; imemaddr = 32'h0;
    #3;
    check("stats hit1", {31'd0, ihit}, 32'd1);
    step;
    imemREN = 1'b0;
    #3;
    check("stats miss_count", miss_count, 32'd2);
    check("stats hit_count", hit_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch port and the memory arbiter.
- Serves the fetch stage through `imemREN`, `imemaddr`, `ihit` and `imemload`.
- On a miss, issues a single-word fill to memory over `iREN`, `iaddr`, `iwait` and `iload`.
- Hits complete in the same cycle. Misses stall fetch until the frame is filled.

## Interface
Parameters:
- `SETS`, default 16: number of frames, power of two; `IDX_W = $clog2(SETS)`.
- `WORD_W`, default 32: data and address width.

Ports:
- `CLK` in 1: clock, rising edge. One clock.
- `nRST` in 1: reset, synchronous, active-low.
- `imemREN` in 1: fetch read request.
- `imemaddr` in 32: fetch byte address, word aligned.
- `ihit` out 1: requested word valid on `imemload` this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: memory read request.
- `iaddr` out 32: memory word address.
- `iwait` in 1: memory busy. Low means `iload` is valid this cycle.
- `iload` in 32: memory read data.
- `hit_count` out 32: present only with `ICACHE_STATS_EN`.
- `miss_count` out 32: present only with `ICACHE_STATS_EN`.

## Operation
Address split:
- `tag = imemaddr[31:IDX_W+2]`
- `idx = imemaddr[IDX_W+1:2]`
- `[1:0]` is ignored.

Frame contents: `valid`, `tag`, `data`.

Hit condition: `hit = frame[idx].valid && frame[idx].tag == tag`.

State machine, states IDLE and MISS:
- **IDLE**
  - `ihit = imemREN & hit` and `imemload = frame[idx].data`, both combinational.
  - If `imemREN & ~hit`: latch `imemaddr` into `miss_addr` and go to MISS. `ihit` stays 0.
  - If `imemREN` is 0: `ihit = 0`, no state change.
- **MISS**
  - `iREN = 1`, `iaddr = miss_addr`, `ihit = 0`.
  - On the edge where `iwait = 0`: write `frame[miss_addr idx] = {1, miss_addr tag, iload}` and go to IDLE.
  - While `iwait = 1`: remain in MISS.
- `imemload` is don't-care when `ihit = 0`. The implementation drives the indexed frame data.

Boundary conditions:
- **`imemREN` drops or `imemaddr` changes mid-miss** (branch redirect, halt): the fill to `miss_addr` still completes, so the arbiter is never abandoned mid-transaction. The new address is evaluated in IDLE on the following cycle.
- **Conflict miss:** a miss to an index holding a different tag overwrites that frame. There is no victim state.
- **Reset mid-miss:** the next edge with `nRST = 0` forces IDLE and clears every `valid`. The in-flight memory read is dropped; the arbiter tolerates `iREN` falling.
- **`iwait = 0` in IDLE:** ignored.

## Timing
- Hit latency: 0 cycles. `ihit` is asserted in the request cycle.
- Miss latency:
  - 1 cycle to enter MISS, then N cycles until `iwait` falls.
  - Fill is written on that edge.
  - Hit is reported 1 cycle after the fill.
  - Total N+2 cycles from request to `ihit`. `ihit` is never asserted in the fill cycle.
- Reset values:
  - State IDLE, all `valid = 0`.
  - `ihit = 0`, `iREN = 0`, `iaddr = 0`.
  - `hit_count = 0`, `miss_count = 0`.
- While `nRST = 0`, `ihit` and `iREN` are forced to 0 combinationally.

## Configuration
- Macro `ICACHE_STATS_EN`:
  - **Defined:**
    - `hit_count` increments on each IDLE cycle with `imemREN & hit`.
    - `miss_count` increments on each IDLE→MISS transition.
    - Both wrap modulo 2^32 and both are cleared by reset.
  - **Undefined:** the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` holds:
  - `icache_frame_t`, a packed struct `{valid, tag, data}`;
  - `icache_state_t`, enum `{IDLE, MISS}`;
  - `ICACHE_IDX_W` and `ICACHE_TAG_W` localparams for the default geometry.
- One sub-module is natural: `icache_frame_array`, holding the `SETS`-entry frame storage.
  - Combinational read by `idx`.
  - One synchronous write port.
  - Synchronous valid-clear on reset.
- The FSM and the optional counters live in `icache`.

## Test plan
- **Cold miss:** reset, then `imemREN = 1`, `imemaddr = 0x0000_0040`, memory returns `0x2408_0001` with `iwait` high for 3 cycles. Required response:
  - `iREN = 1` and `iaddr = 0x40` for 4 cycles;
  - `ihit = 1` with `imemload = 0x2408_0001` exactly 5 cycles after the request.
- **Hit after fill:** re-request `0x40`. Required response: `ihit = 1` in the same cycle, `iREN` stays 0.
- **Conflict:** fill `0x40`, then request `0x440` (same idx, different tag). Required response:
  - miss, frame replaced;
  - a re-request of `0x40` misses again.
- **Redirect mid-miss:** miss on `0x80`, then move `imemaddr` to `0xC0` while `iwait = 1`. Required response:
  - `iaddr` stays `0x80` until `iwait` falls;
  - then a second miss is issued for `0xC0`.
- **Reset mid-miss:** pull `nRST` low during MISS. Required response:
  - `iREN = 0` immediately, state IDLE;
  - a later request for the same address misses.
- **Stats** (with `ICACHE_STATS_EN`): sequence 0x0, 0x0, 0x4, 0x0 from cold. Required response: `miss_count = 2`, `hit_count = 2`.
